// File: rtl/mips_mem_responder.sv
// Byte-wide memory responder for the 8-bit multicycle MIPS core.
// A boot loader streams a program image in over a valid/ready byte stream while
// the core is held in reset. Once the image is loaded the core is released and
// its fetch/load/store accesses are served with a one-cycle registered read.
module mips_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   load_count,
  output logic              oob_err
);

  // Index width of the storage array; DEPTH is at least 2, so this is >= 1.
  localparam int IDX_W = $clog2(DEPTH);
  // Last legal load pointer: a handshake here ends the load even without load_last.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  // DEPTH extended by one bit so the range check also works when DEPTH == 2^ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [ADDR_W:0]     count_r;
  logic [DATA_W-1:0]   memdata_r;
  logic                load_ready_r;
  logic                cpu_reset_r;
  logic                oob_r;

  logic                hs_s;
  logic                in_range_s;
  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_widx_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  // Storage array; deliberately not cleared by reset so an image survives a core restart.
  logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

  // Next-state decode plus the single shared memory write port (loader or core).
  always_comb begin
    state_next_s = state_r;
    hs_s         = 1'b0;
    mem_we_s     = 1'b0;
    mem_widx_s   = {IDX_W{1'b0}};
    mem_wdata_s  = {DATA_W{1'b0}};
    in_range_s   = ({1'b0, adr} < DEPTH_EXT);
    case (state_r)
      S_LOAD: begin
        hs_s = load_valid & load_ready_r;
        if (hs_s) begin
          mem_we_s    = 1'b1;
          mem_widx_s  = ptr_r[IDX_W-1:0];
          mem_wdata_s = load_data;
          if (load_last || (ptr_r == LAST_PTR)) begin
            state_next_s = S_RUN;
          end else begin
            state_next_s = S_LOAD;
          end
        end else begin
          state_next_s = S_LOAD;
        end
      end
      S_RUN: begin
        state_next_s = S_RUN;
        if (memwrite && in_range_s) begin
          mem_we_s    = 1'b1;
          mem_widx_s  = adr[IDX_W-1:0];
          mem_wdata_s = writedata;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        state_next_s = S_LOAD;
      end
    endcase
  end

  // Memory write port; a read in the same cycle sees the old contents (read-first).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  // State, loader bookkeeping and registered outputs to core and host.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_LOAD;
      ptr_r        <= {ADDR_W{1'b0}};
      count_r      <= {(ADDR_W + 1){1'b0}};
      memdata_r    <= {DATA_W{1'b0}};
      load_ready_r <= 1'b0;
      cpu_reset_r  <= 1'b1;
      oob_r        <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      load_ready_r <= (state_next_s == S_LOAD);
      cpu_reset_r  <= (state_next_s == S_LOAD);
      if (hs_s) begin
        count_r <= count_r + (ADDR_W + 1)'(1'b1);
      end
      // The pointer stops at the final byte instead of wrapping.
      if (hs_s && (state_next_s == S_LOAD)) begin
        ptr_r <= ptr_r + ADDR_W'(1'b1);
      end
      if ((state_r == S_RUN) && memread) begin
        memdata_r <= in_range_s ? mem_r[adr[IDX_W-1:0]] : {DATA_W{1'b0}};
      end
      if ((state_r == S_RUN) && (memread || memwrite) && !in_range_s) begin
        oob_r <= 1'b1;
      end
    end
  end

  assign memdata    = memdata_r;
  assign load_ready = load_ready_r;
  assign cpu_reset  = cpu_reset_r;
  assign load_count = count_r;
  assign oob_err    = oob_r;

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Byte-wide memory responder serving the 8-bit multicycle MIPS core's memory port (memread/memwrite/adr/writedata in, memdata out).
- Includes a boot loader FSM. A host streams a program image in over a valid/ready byte stream while the core is held in reset via cpu_reset.
- After loading, the block releases the core and services its fetch, load and store accesses with a fixed one-cycle registered read.

Parameters:
- ADDR_W, 8, address width; matches the core's adr bus.
- DATA_W, 8, data width; matches memdata/writedata.
- DEPTH, 256, implemented bytes; legal range 2..2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- memread  input  1  core read strobe.
- memwrite  input  1  core write strobe.
- adr  input  ADDR_W  core byte address.
- writedata  input  DATA_W  core store data.
- memdata  output  DATA_W  registered read data to the core.
- load_valid  input  1  host byte valid.
- load_data  input  DATA_W  host byte.
- load_last  input  1  marks the final byte of the image; qualified by load_valid.
- load_ready  output  1  block accepts a host byte this cycle.
- cpu_reset  output  1  drives the core's reset input; high while loading.
- load_count  output  ADDR_W+1  bytes accepted in the current load.
- oob_err  output  1  sticky flag set by a core access with adr >= DEPTH.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - state = S_LOAD, load pointer = 0, load_count = 0
  - memdata = 0, cpu_reset = 1, load_ready = 0, oob_err = 0
  - Memory array is NOT cleared.
- States: S_LOAD, S_RUN. Two-state FSM, registered outputs.
- S_LOAD:
  - load_ready = 1 in every cycle except the reset cycle; cpu_reset = 1.
  - A handshake is load_valid & load_ready. On each handshake: mem[ptr] <= load_data, ptr <= ptr+1, load_count <= load_count+1.
  - Handshake with load_last = 1 -> S_RUN next cycle.
  - Handshake at ptr = DEPTH-1 without load_last -> S_RUN next cycle (image full). The pointer does not wrap.
  - memread/memwrite are ignored; memdata holds 0.
- Transition S_LOAD->S_RUN:
  - load_ready deasserts in the cycle after the final handshake.
  - cpu_reset deasserts in that same cycle.
  - load_count holds its final value.
- S_RUN:
  - load_ready = 0; load_valid is ignored.
  - Stays in S_RUN until reset.
- Read (S_RUN): memread=1 at edge N -> memdata = mem[adr] valid after edge N; one cycle latency.
  - memdata holds its last value while memread=0.
- Write (S_RUN): memwrite=1 -> mem[adr] <= writedata at that edge. No response signal.
- Simultaneous memread and memwrite, same address: write executes; memdata returns the OLD contents (read-first).
- Out of range (adr >= DEPTH, only possible when DEPTH < 2^ADDR_W):
  - Read returns 0.
  - Write is dropped.
  - oob_err sets and stays set until reset.
- Reset mid-load or mid-run: returns to S_LOAD with ptr = 0 and cpu_reset = 1. Already-written bytes persist until overwritten.
- Widths: ptr is ADDR_W bits. load_count is ADDR_W+1 bits so a full 256-byte image reports 256.

Test Plan:
- Reset, then stream 4 bytes 0x80,0x44,0x00,0x20 with load_last on the 4th -> load_count=4, cpu_reset low one cycle after the 4th handshake; memread at adr 0..3 returns those bytes each one cycle later.
- Hold load_valid=0 for 5 cycles mid-stream, then drive load_valid with load_ready low after S_RUN -> no pointer advance during the gap, no extra write after S_RUN, load_count unchanged.
- DEPTH=256, stream 256 bytes (value = index) without load_last -> S_RUN after byte 255, load_count=256; mem[0xFF]=0xFF, mem[0x00]=0x00 (no wrap).
- S_RUN: mem[0x10]=0x3C; assert memwrite=1 and memread=1, adr=0x10, writedata=0xA5 -> memdata=0x3C next cycle; next read of 0x10 returns 0xA5.
- DEPTH=128: write 0x55 to adr 0x90, then read 0x90 -> memdata=0x00, oob_err=1 and stays 1; mem[0x10] unaffected.
- Assert reset for 1 cycle in S_RUN -> cpu_reset=1, load_ready=1 the next cycle, load_count=0; earlier contents are still readable after a 1-byte reload with load_last.
